// File: rtl/fft_output_reorder.sv
// FFT output reorder: bit-reversed pair stream into natural-order frames.
// Ping-pong banks, one complete frame presented per valid/ready handshake.
package fft_output_reorder_pkg;
    localparam int DW = 16;

    typedef struct packed {
        logic signed [DW-1:0] r;
        logic signed [DW-1:0] i;
    } complex_t;

    typedef struct packed {
        logic signed [2*DW-1:0] r;
        logic signed [2*DW-1:0] i;
    } complex_product_t;
endpackage

module fft_output_reorder
    import fft_output_reorder_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in_first,
    input  complex_product_t             in0,
    input  complex_product_t             in1,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output complex_product_t [N-1:0]     y,
    output logic                         overflow,
    output logic                         sync_err
);

    localparam int L  = $clog2(N);
    localparam int P  = N / 2;
    localparam int CW = L - 1;
    localparam int SW = 4 * DATA_WIDTH;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_st_e;

    bank_st_e        st   [2];
    bank_st_e        st_n [2];
    logic            wr, wr_n;
    logic            rd, rd_n;
    logic [CW-1:0]   cnt, cnt_n, cnt_w;
    logic [SW-1:0]   mem [2][N];
    logic            accept, drain, resync, last;
    logic            in_ready_n, out_valid_n;
    logic [L-1:0]    idx0, idx1;

    function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
        logic [L-1:0] r;
        for (int b = 0; b < L; b++) r[b] = v[L-1-b];
        return r;
    endfunction

    // Next-state of both banks, pointers, pair counter and handshake flags
    always_comb begin
        accept = in_valid && in_ready;
        drain  = out_valid && out_ready;
        resync = accept && in_first && (cnt != '0);
        cnt_w  = in_first ? '0 : cnt;
        last   = accept && !resync && (cnt == CW'(P - 1));
        idx0   = bitrev({cnt_w, 1'b0});
        idx1   = bitrev({cnt_w, 1'b1});
        st_n   = st;
        wr_n   = wr;
        rd_n   = rd;
        cnt_n  = cnt;
        if (accept) begin
            cnt_n = cnt_w + CW'(1);
            if (st[wr] == EMPTY) st_n[wr] = FILLING;
            if (last) begin
                st_n[wr] = FULL;
                wr_n     = ~wr;
                cnt_n    = '0;
            end
        end
        if (drain) begin
            st_n[rd] = EMPTY;
            rd_n     = ~rd;
        end
        in_ready_n = !((st_n[0] == FULL) && (st_n[1] == FULL));
        // A drain hands straight over to an already-complete other bank;
        // otherwise a freshly completed bank shows one cycle later.
        out_valid_n = drain ? (st_n[rd_n] == FULL) : (st[rd] == FULL);
    end

    // Bank state machines, pointers and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            st[0]     <= EMPTY;
            st[1]     <= EMPTY;
            wr        <= 1'b0;
            rd        <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            st        <= st_n;
            wr        <= wr_n;
            rd        <= rd_n;
            cnt       <= cnt_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            overflow  <= overflow | (in_valid && !in_ready);
            sync_err  <= sync_err | resync;
        end
    end

    // Sample storage; scattered to natural order on write, never cleared
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr][idx0] <= in0;
            mem[wr][idx1] <= in1;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_y
        assign y[g] = out_valid ? complex_product_t'(mem[rd][g]) : '0;
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Testbench for fft_output_reorder: frame-queue reference model plus
// directed literal checks and a randomized streaming phase.
module tb_fft_output_reorder;
    import fft_output_reorder_pkg::*;

    localparam int N  = 8;
    localparam int L  = 3;
    localparam int YW = $bits(complex_product_t) * N;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_first;
    complex_product_t         in0;
    complex_product_t         in1;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    complex_product_t [N-1:0] y;
    logic                     overflow;
    logic                     sync_err;

    int n_chk  = 0;
    int n_fail = 0;

    fft_output_reorder #(.DATA_WIDTH(16), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in0       (in0),
        .in1       (in1),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .overflow  (overflow),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [YW-1:0] act,
                       input logic [YW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int b = 0; b < L; b++) r = (r << 1) | ((v >> b) & 1);
        return r;
    endfunction

    function automatic complex_product_t mk(input int v);
        complex_product_t c;
        c.r = 32'(v);
        c.i = 32'(-v);
        return c;
    endfunction

    // Reference model: completed frames queue up in arrival order; each
    // becomes visible one cycle after completion, or at once when it
    // inherits the head slot through a drain.
    int                       cyc = 0;
    bit                       m_started = 0;
    bit                       m_ready = 1;
    bit                       m_ovf = 0;
    bit                       m_serr = 0;
    int                       pcnt = 0;
    complex_product_t [N-1:0] pbuf;
    complex_product_t [N-1:0] fq_d[$];
    int                       fq_a[$];

    always @(posedge clk) begin
        bit drn;
        drn = m_started && (fq_a.size() > 0) && (fq_a[0] <= cyc) && out_ready;
        cyc++;
        if (reset) begin
            m_started = 1;
            fq_d.delete();
            fq_a.delete();
            pcnt    = 0;
            m_ready = 1;
            m_ovf   = 0;
            m_serr  = 0;
        end else if (m_started) begin
            if (in_valid) begin
                if (!m_ready) m_ovf = 1;
                else begin
                    if (in_first && pcnt != 0) begin
                        m_serr = 1;
                        pcnt   = 0;
                    end
                    pbuf[bitrev(2*pcnt)]   = in0;
                    pbuf[bitrev(2*pcnt+1)] = in1;
                    pcnt++;
                    if (pcnt == N/2) begin
                        fq_d.push_back(pbuf);
                        fq_a.push_back(cyc + 1);
                        pcnt = 0;
                    end
                end
            end
            if (drn) begin
                fq_d.delete(0);
                fq_a.delete(0);
                if (fq_a.size() > 0 && fq_a[0] > cyc) fq_a[0] = cyc;
            end
            m_ready = fq_d.size() < 2;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            bit ev;
            complex_product_t [N-1:0] ey;
            ev = (fq_a.size() > 0) && (fq_a[0] <= cyc);
            ey = '0;
            if (ev) ey = fq_d[0];
            chk("m_out_valid", out_valid, ev);
            chk("m_in_ready", in_ready, m_ready);
            chk("m_overflow", overflow, m_ovf);
            chk("m_sync_err", sync_err, m_serr);
            chk("m_y", y, ey);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input complex_product_t a,
                              input complex_product_t b,
                              input logic first);
        in_valid = 1'b1;
        in0      = a;
        in1      = b;
        in_first = first;
        step();
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic send_frame_nat(input int base);
        for (int k = 0; k < N/2; k++)
            drive_pair(mk(base + bitrev(2*k)), mk(base + bitrev(2*k+1)),
                       k == 0);
    endtask

    task automatic chk_frame(input string nm, input int base);
        for (int i = 0; i < N; i++) begin
            chk({nm, "_r"}, y[i].r, base + i);
            chk({nm, "_i"}, y[i].i, -(base + i));
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        out_ready = 1'b0;
        step();
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_y", y, 0);
    endtask

    initial begin
        int tb_pk;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in0       = '0;
        in1       = '0;
        out_ready = 1'b0;

        // N=8 reorder with literal expectations, then hold and drain
        do_reset();
        drive_pair(mk(0), mk(4), 1'b1);
        drive_pair(mk(2), mk(6), 1'b0);
        drive_pair(mk(1), mk(5), 1'b0);
        drive_pair(mk(3), mk(7), 1'b0);
        chk("t1_valid_early", out_valid, 0);
        step();
        chk("t1_valid", out_valid, 1);
        chk_frame("t1_y", 0);
        for (int h = 0; h < 10; h++) begin
            step();
            chk("hold_valid", out_valid, 1);
            chk_frame("hold_y", 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("drain_valid", out_valid, 0);
        chk("drain_y", y, 0);

        // Ping-pong streaming, consumer always ready
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            chk("pp_valid", out_valid, (k == 5 || k == 9 || k == 13));
            chk("pp_in_ready", in_ready, 1);
            chk("pp_overflow", overflow, 0);
            if (k < 12)
                drive_pair(mk(1000 + 2*k), mk(1001 + 2*k), (k % 4) == 0);
            else
                step();
        end

        // Back-pressure: two frames buffered, third dropped
        do_reset();
        for (int k = 0; k < 12; k++) begin
            int f, p;
            chk("bp_in_ready", in_ready, k < 8);
            chk("bp_overflow", overflow, k >= 9);
            f = 100 * (k / 4 + 1);
            p = k % 4;
            drive_pair(mk(f + bitrev(2*p)), mk(f + bitrev(2*p+1)), p == 0);
        end
        chk("bp_valid", out_valid, 1);
        chk_frame("bp_f1", 100);
        out_ready = 1'b1;
        step();
        chk("bp_valid2", out_valid, 1);
        chk_frame("bp_f2", 200);
        step();
        chk("bp_valid3", out_valid, 0);
        chk("bp_in_ready_back", in_ready, 1);
        out_ready = 1'b0;

        // Resync on in_first mid-frame
        do_reset();
        drive_pair(mk(900), mk(901), 1'b1);
        drive_pair(mk(902), mk(903), 1'b0);
        chk("rs_serr_before", sync_err, 0);
        send_frame_nat(500);
        step();
        chk("rs_serr", sync_err, 1);
        chk("rs_valid", out_valid, 1);
        chk_frame("rs_y", 500);

        // Mid-frame reset, then a clean frame
        do_reset();
        drive_pair(mk(700), mk(701), 1'b1);
        drive_pair(mk(702), mk(703), 1'b0);
        drive_pair(mk(704), mk(705), 1'b0);
        do_reset();
        send_frame_nat(300);
        step();
        chk("mr_valid", out_valid, 1);
        chk("mr_serr", sync_err, 0);
        chk_frame("mr_y", 300);

        // Randomized traffic against the model
        do_reset();
        tb_pk = 0;
        for (int c = 0; c < 3000; c++) begin
            int pr;
            pr        = ((c / 200) % 2) ? 2 : 8;
            reset     = ($urandom_range(0, 999) < 3);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_first  = (tb_pk == 0) ^ ($urandom_range(0, 29) == 0);
            in0       = {$urandom(), $urandom()};
            in1       = {$urandom(), $urandom()};
            out_ready = ($urandom_range(0, 9) < pr);
            step();
            if (reset) tb_pk = 0;
            else if (in_valid) tb_pk = (tb_pk + 1) % (N/2);
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
